// File: rtl/i2c_byte_engine.sv
// ---------------------------------------------------------------------------
// i2c_byte_engine
//
// Byte-level I2C master sequencer for a pair of open-drain pads. Each pad is a
// tristate cell whose output data is tied low, so the engine only controls the
// output enables: oe=1 pulls the line low and oe=0 releases it. Commands
// arrive on a valid/ready handshake. Each bus sequence (START, STOP,
// WRITE, READ) is built from 4-phase steps of clkdiv+1 cycles. Phase 1 of
// every step releases SCL, and the counter waits there while the target
// stretches the clock.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   clkdiv          quarter-bit length minus one, latched at command accept
//   cmd_valid/ready command handshake (ready only in IDLE)
//   cmd             0 START, 1 STOP, 2 WRITE, 3 READ
//   cmd_wdata       byte to transmit (WRITE)
//   cmd_nack        ack bit sent after a READ (1 = NACK)
//   rsp_valid       one-cycle pulse when a WRITE or READ completes
//   rsp_rdata       last received byte
//   rsp_nack        ack bit sampled from the target after a WRITE
//   bus_owned       high between START completion and STOP completion
//   scl_oe, sda_oe  registered pad output enables (1 = drive low)
//   scl_in, sda_in  synchronised pad inputs
// ---------------------------------------------------------------------------
module i2c_byte_engine #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic [7:0]       cmd_wdata,
    input  logic             cmd_nack,
    output logic             rsp_valid,
    output logic [7:0]       rsp_rdata,
    output logic             rsp_nack,
    output logic             bus_owned,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             scl_in,
    input  logic             sda_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BIT   = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_READ  = 2'd3;

    state_t           state, state_n;
    logic [1:0]       phase, phase_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [3:0]       bit_idx, bit_n;
    logic [7:0]       sh, sh_n;          // WRITE: data to send; READ: samples
    logic             sample_q, sample_n;
    logic [1:0]       cmd_q, cmd_n;
    logic             nack_q, nack_n;
    logic             skip_q, skip_n;    // command issued without owning the bus
    logic             bus_owned_n;
    logic             rsp_valid_n;
    logic [7:0]       rsp_rdata_n;
    logic             rsp_nack_n;
    logic             scl_oe_n, sda_oe_n;
    logic             stretch_wait;
    logic             phase_done;
    logic             bit_val;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed by the combinational processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase     <= 2'd0;
            cnt       <= '0;
            div_q     <= '0;
            bit_idx   <= 4'd0;
            sh        <= 8'h00;
            sample_q  <= 1'b0;
            cmd_q     <= CMD_START;
            nack_q    <= 1'b0;
            skip_q    <= 1'b0;
            bus_owned <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            cnt       <= cnt_n;
            div_q     <= div_n;
            bit_idx   <= bit_n;
            sh        <= sh_n;
            sample_q  <= sample_n;
            cmd_q     <= cmd_n;
            nack_q    <= nack_n;
            skip_q    <= skip_n;
            bus_owned <= bus_owned_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_nack  <= rsp_nack_n;
            scl_oe    <= scl_oe_n;
            sda_oe    <= sda_oe_n;
        end
    end

    // Phase 1 of every sequence releases SCL; while the target holds it low
    // the counter stays at zero and counting starts once SCL reads high.
    assign stretch_wait = (phase == 2'd1) && !scl_in;
    assign phase_done   = (cnt == div_q) && !stretch_wait;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        cnt_n       = cnt;
        div_n       = div_q;
        bit_n       = bit_idx;
        sh_n        = sh;
        sample_n    = sample_q;
        cmd_n       = cmd_q;
        nack_n      = nack_q;
        skip_n      = skip_q;
        bus_owned_n = bus_owned;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_nack_n  = rsp_nack;

        if (state == S_IDLE) begin
            if (cmd_valid) begin
                div_n   = clkdiv;
                cmd_n   = cmd;
                nack_n  = cmd_nack;
                phase_n = 2'd0;
                cnt_n   = '0;
                bit_n   = 4'd0;
                sh_n    = (cmd == CMD_WRITE) ? cmd_wdata : 8'h00;
                skip_n  = (cmd != CMD_START) && !bus_owned;
                case (cmd)
                    CMD_START: state_n = S_START;
                    CMD_STOP:  state_n = S_STOP;
                    default:   state_n = S_BIT;
                endcase
            end
        end else if (skip_q) begin
            // No bus to talk on: finish in one cycle without touching the pads.
            state_n = S_IDLE;
            skip_n  = 1'b0;
            if (cmd_q == CMD_WRITE || cmd_q == CMD_READ) begin
                rsp_valid_n = 1'b1;
                rsp_nack_n  = 1'b1;
            end
        end else begin
            if (stretch_wait || cnt == div_q)
                cnt_n = '0;
            else
                cnt_n = cnt + {{(DIV_W-1){1'b0}}, 1'b1};

            if (phase_done) begin
                phase_n = phase + 2'd1;
                if (state == S_BIT && phase == 2'd2)
                    sample_n = sda_in;
                if (phase == 2'd3) begin
                    case (state)
                        S_START: begin
                            state_n     = S_IDLE;
                            bus_owned_n = 1'b1;
                        end
                        S_STOP: begin
                            state_n     = S_IDLE;
                            bus_owned_n = 1'b0;
                        end
                        default: begin
                            if (bit_idx == 4'd8) begin
                                state_n     = S_IDLE;
                                rsp_valid_n = 1'b1;
                                if (cmd_q == CMD_WRITE)
                                    rsp_nack_n = sample_q;
                                else
                                    rsp_rdata_n = sh;
                            end else begin
                                bit_n = bit_idx + 4'd1;
                                sh_n  = {sh[6:0], sample_q};
                            end
                        end
                    endcase
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: pad enables for the upcoming cycle, derived from the
    // next phase so the registered pads switch exactly at phase boundaries.
    // -----------------------------------------------------------------------
    always_comb begin
        cmd_ready = (state == S_IDLE);
        scl_oe_n  = scl_oe;
        sda_oe_n  = sda_oe;

        // Data bit for the bit about to start (1 = released line).
        if (bit_n == 4'd8)
            bit_val = (cmd_n == CMD_WRITE) ? 1'b1 : nack_n;
        else
            bit_val = (cmd_n == CMD_WRITE) ? sh_n[7] : 1'b1;

        if (!skip_n) begin
            case (state_n)
                S_START: begin
                    case (phase_n)
                        2'd0:    sda_oe_n = 1'b0;
                        2'd1:    begin scl_oe_n = 1'b0; sda_oe_n = 1'b0; end
                        2'd2:    begin scl_oe_n = 1'b0; sda_oe_n = 1'b1; end
                        default: begin scl_oe_n = 1'b1; sda_oe_n = 1'b1; end
                    endcase
                end
                S_BIT: begin
                    case (phase_n)
                        2'd0:    begin scl_oe_n = 1'b1; sda_oe_n = !bit_val; end
                        2'd1:    scl_oe_n = 1'b0;
                        2'd2:    scl_oe_n = 1'b0;
                        default: scl_oe_n = 1'b1;
                    endcase
                end
                S_STOP: begin
                    case (phase_n)
                        2'd0:    begin scl_oe_n = 1'b1; sda_oe_n = 1'b1; end
                        2'd1:    begin scl_oe_n = 1'b0; sda_oe_n = 1'b1; end
                        default: begin scl_oe_n = 1'b0; sda_oe_n = 1'b0; end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// ---------------------------------------------------------------------------
// tb_i2c_byte_engine
//
// Directed bench for i2c_byte_engine with clkdiv=3 (4-cycle phases). The pads
// are a wired-AND of the engine enables and a scripted target. Cycle 0 is the
// accept cycle of each command; expected timings are worked out by hand from
// the phase structure (16 cycles per bit, 144 per byte).
// ---------------------------------------------------------------------------
module tb_i2c_byte_engine;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIV_W-1:0] clkdiv = 16'd3;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd = 2'd0;
    logic [7:0]       cmd_wdata = 8'h00;
    logic             cmd_nack = 1'b0;
    logic             rsp_valid;
    logic [7:0]       rsp_rdata;
    logic             rsp_nack;
    logic             bus_owned;
    logic             scl_oe, sda_oe;
    logic             scl_in, sda_in;

    logic             tgt_scl = 1'b0;   // target pulls SCL low
    logic             tgt_sda = 1'b0;   // target pulls SDA low

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;

    logic             cap_en = 1'b0;
    logic             scl_prev = 1'b1;
    logic             cap_bits[$];
    logic [7:0]       cap_byte;
    logic [7:0]       rd_pat;

    assign scl_in = ~(scl_oe | tgt_scl);
    assign sda_in = ~(sda_oe | tgt_sda);

    always #5 clk = ~clk;

    i2c_byte_engine #(.DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clkdiv    (clkdiv),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_wdata (cmd_wdata),
        .cmd_nack  (cmd_nack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .bus_owned (bus_owned),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    // Record the SDA line on every SCL rising edge while capture is enabled.
    always @(negedge clk) begin
        scl_prev <= scl_in;
        if (cap_en && !scl_prev && scl_in)
            cap_bits.push_back(sda_in);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; inputs and checks sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cyc++;
    endtask

    // Present a command in the current cycle, which becomes cycle 0.
    task automatic issue(input logic [1:0] c, input logic [7:0] wd, input logic nk);
        cmd       = c;
        cmd_wdata = wd;
        cmd_nack  = nk;
        cmd_valid = 1'b1;
        cyc       = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl_oe",    scl_oe,    0);
        check("rst_sda_oe",    sda_oe,    0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_rsp_nack",  rsp_nack,  0);
        check("rst_bus_owned", bus_owned, 0);
        rst_n = 1'b1;
        step();

        // ---------------- START: 16 cycles ----------------
        issue(2'd0, 8'h00, 1'b0);
        while (cyc < 17) begin
            step();
            if (cyc == 9) begin
                check("start_p2_scl", scl_oe, 0);
                check("start_p2_sda", sda_oe, 1);
            end
            if (cyc == 16) begin
                check("start_busy",      cmd_ready, 0);
                check("start_not_owned", bus_owned, 0);
            end
            if (cyc == 17) begin
                check("start_done_ready", cmd_ready, 1);
                check("start_done_owned", bus_owned, 1);
                check("start_done_scl",   scl_oe,    1);
                check("start_done_sda",   sda_oe,    1);
            end
        end

        // ---------------- WRITE 0xA5, target ACKs ----------------
        cap_bits.delete();
        cap_en = 1'b1;
        issue(2'd2, 8'hA5, 1'b0);
        while (cyc < 146) begin
            step();
            tgt_sda = (cyc >= 129 && cyc <= 144);
            if (cyc == 144) check("wr_a5_rsp_early", rsp_valid, 0);
            if (cyc == 145) begin
                check("wr_a5_rsp_valid", rsp_valid, 1);
                check("wr_a5_rsp_nack",  rsp_nack,  0);
                check("wr_a5_owned",     bus_owned, 1);
            end
            if (cyc == 146) check("wr_a5_rsp_pulse", rsp_valid, 0);
        end
        cap_en = 1'b0;
        check("wr_a5_rises", cap_bits.size(), 9);
        cap_byte = 8'h00;
        for (int i = 0; i < 8 && i < cap_bits.size(); i++)
            cap_byte = {cap_byte[6:0], cap_bits[i]};
        check("wr_a5_sda_bits", cap_byte, 8'hA5);

        // ---------------- WRITE 0x3C, no target ----------------
        issue(2'd2, 8'h3C, 1'b0);
        while (cyc < 145) begin
            step();
            if (cyc == 145) begin
                check("wr_3c_rsp_valid", rsp_valid, 1);
                check("wr_3c_rsp_nack",  rsp_nack,  1);
                check("wr_3c_owned",     bus_owned, 1);
            end
        end

        // ---------------- WRITE 0x5A with 50-cycle stretch in bit 3 ----------------
        issue(2'd2, 8'h5A, 1'b0);
        while (cyc < 195) begin
            step();
            tgt_scl = (cyc >= 37 && cyc <= 86);
            if (cyc == 60) begin
                check("str_scl_released", scl_oe, 0);
                check("str_sda_stable",   sda_oe, 1);
            end
            if (cyc == 86)  check("str_sda_end",     sda_oe,    1);
            if (cyc == 145) check("str_no_rsp_145",  rsp_valid, 0);
            if (cyc == 194) check("str_no_rsp_194",  rsp_valid, 0);
            if (cyc == 195) check("str_rsp_195",     rsp_valid, 1);
        end
        tgt_scl = 1'b0;

        // ---------------- READ 0x96 with NACK ----------------
        rd_pat = 8'h96;
        issue(2'd3, 8'h00, 1'b1);
        while (cyc < 145) begin
            step();
            if (cyc <= 128)
                tgt_sda = ~rd_pat[7 - (cyc - 1) / 16];
            else
                tgt_sda = 1'b0;
            if (cyc == 133) check("rd_bit9_sda_released", sda_oe, 0);
            if (cyc == 145) begin
                check("rd_rsp_valid", rsp_valid, 1);
                check("rd_rdata",     rsp_rdata, 8'h96);
            end
        end

        // ---------------- STOP ----------------
        issue(2'd1, 8'h00, 1'b0);
        while (cyc < 17) begin
            step();
            if (cyc == 16) check("stop_still_owned", bus_owned, 1);
            if (cyc == 17) begin
                check("stop_scl_oe",    scl_oe,    0);
                check("stop_sda_oe",    sda_oe,    0);
                check("stop_bus_owned", bus_owned, 0);
                check("stop_ready",     cmd_ready, 1);
            end
        end

        // ---------------- WRITE without owning the bus ----------------
        issue(2'd2, 8'h55, 1'b0);
        while (cyc < 2) begin
            step();
            check("nobus_scl_oe", scl_oe, 0);
            check("nobus_sda_oe", sda_oe, 0);
            if (cyc == 1) begin
                check("nobus_busy",   cmd_ready, 0);
                check("nobus_no_rsp", rsp_valid, 0);
            end
            if (cyc == 2) begin
                check("nobus_rsp_valid", rsp_valid, 1);
                check("nobus_rsp_nack",  rsp_nack,  1);
                check("nobus_rdata",     rsp_rdata, 8'h96);
            end
        end

        // ---------------- reset in the middle of a READ ----------------
        issue(2'd0, 8'h00, 1'b0);
        while (cyc < 17) step();
        issue(2'd3, 8'h00, 1'b0);
        while (cyc < 130) step();
        check("mid_rd_scl_driven", scl_oe, 1);
        check("mid_rd_sda_ack",    sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("arst_scl_oe",    scl_oe,    0);
        check("arst_sda_oe",    sda_oe,    0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_bus_owned", bus_owned, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
